// File: rtl/bufmem_arbiter_if.sv
// Bus bundle for the sector-buffer arbiter. It carries the three requester
// ports, the read return, the RAM1024x8 port and the contention counter.
interface bufmem_arbiter_if;
    // WD1793 buffer port
    logic        wd_req;
    logic        wd_we;
    logic [9:0]  wd_addr;
    logic [7:0]  wd_wdata;
    // DMA engine port
    logic        dma_req;
    logic        dma_we;
    logic [9:0]  dma_addr;
    logic [7:0]  dma_wdata;
    // 6502 port (full CPU address space)
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    // grants and read return
    logic        wd_ack;
    logic        dma_ack;
    logic        cpu_ack;
    logic        wd_rvalid;
    logic        dma_rvalid;
    logic        cpu_rvalid;
    logic [7:0]  rdata;
    logic        cpu_stall;
    // RAM1024x8 port
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic        mem_clken;
    logic [7:0]  mem_rdata;
    logic [7:0]  conflict_cnt;

    // arbiter side
    modport slave (
        input  wd_req, wd_we, wd_addr, wd_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output wd_ack, dma_ack, cpu_ack,
        output wd_rvalid, dma_rvalid, cpu_rvalid, rdata, cpu_stall,
        output mem_addr, mem_wdata, mem_wren, mem_clken,
        output conflict_cnt
    );

    // requester / environment side
    modport master (
        output wd_req, wd_we, wd_addr, wd_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  wd_ack, dma_ack, cpu_ack,
        input  wd_rvalid, dma_rvalid, cpu_rvalid, rdata, cpu_stall,
        input  mem_addr, mem_wdata, mem_wren, mem_clken,
        input  conflict_cnt
    );
endinterface

// File: rtl/bufmem_arbiter.sv
// Three-way arbiter (WD1793 > DMA > 6502) for a shared 1 KiB sector buffer.
// Grants are combinational within a ce cycle; reads return one ce cycle later.
// A long DMA burst yields one slot to a waiting CPU after DMA_MAXRUN grants.
module bufmem_arbiter #(
    parameter logic [15:0] BUF_BASE   = 16'h0200,
    parameter int unsigned DMA_MAXRUN = 16
) (
    input logic             clk,
    input logic             reset_n,
    input logic             ce,
    bufmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {OWN_NONE, OWN_WD, OWN_DMA, OWN_CPU} owner_t;

    localparam logic [4:0] RUN_LIMIT = 5'(DMA_MAXRUN);
    localparam logic [4:0] RUN_SAT   = '1;
    localparam logic [7:0] CNT_SAT   = '1;

    owner_t      r_owner;
    owner_t      w_sel;
    owner_t      w_owner_nxt;
    logic        r_rd_pend;
    logic [4:0]  r_dma_run;
    logic [7:0]  r_conflict;
    logic [7:0]  r_rdata;
    logic        r_wd_rv;
    logic        r_dma_rv;
    logic        r_cpu_rv;

    logic [16:0] w_cpu_off;
    logic        w_cpu_valid;
    logic [1:0]  w_nreq;
    logic        w_grant_en;
    logic        w_granted;
    logic        w_sel_we;
    logic        w_cpu_ack;

    // Offset is computed one bit wider so addresses below the window
    // show up as a non-zero upper part instead of wrapping into it.
    assign w_cpu_off   = {1'b0, bus.cpu_addr} - {1'b0, BUF_BASE};
    assign w_cpu_valid = bus.cpu_req && (bus.cpu_addr >= BUF_BASE) && (w_cpu_off[16:10] == '0);
    assign w_nreq      = 2'(bus.wd_req) + 2'(bus.dma_req) + 2'(w_cpu_valid);
    assign w_grant_en  = ce & reset_n;
    assign w_granted   = w_grant_en && (w_sel != OWN_NONE);

    // Next owner: fixed priority with a one-shot CPU slot after a full DMA run
    always_comb begin
        w_sel = OWN_NONE;
        if (bus.wd_req)
            w_sel = OWN_WD;
        else if (w_cpu_valid && (r_dma_run == RUN_LIMIT))
            w_sel = OWN_CPU;
        else if (bus.dma_req)
            w_sel = OWN_DMA;
        else if (w_cpu_valid)
            w_sel = OWN_CPU;
        w_owner_nxt = ce ? w_sel : r_owner;
    end

    // Owner register: last grant, NONE after an idle ce cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_owner <= OWN_NONE;
        else
            r_owner <= w_owner_nxt;
    end

    // Grant outputs and RAM port mux driven by the selected winner
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        w_sel_we      = 1'b0;
        case (w_sel)
            OWN_WD: begin
                bus.mem_addr  = bus.wd_addr;
                bus.mem_wdata = bus.wd_wdata;
                w_sel_we      = bus.wd_we;
            end
            OWN_DMA: begin
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
                w_sel_we      = bus.dma_we;
            end
            OWN_CPU: begin
                bus.mem_addr  = w_cpu_off[9:0];
                bus.mem_wdata = bus.cpu_wdata;
                w_sel_we      = bus.cpu_we;
            end
            default: ;
        endcase
        w_cpu_ack     = w_grant_en && (w_sel == OWN_CPU);
        bus.wd_ack    = w_grant_en && (w_sel == OWN_WD);
        bus.dma_ack   = w_grant_en && (w_sel == OWN_DMA);
        bus.cpu_ack   = w_cpu_ack;
        bus.mem_wren  = w_granted & w_sel_we;
        bus.mem_clken = w_granted;
        bus.cpu_stall = w_cpu_valid & ~w_cpu_ack;
    end

    // Consecutive DMA grant counter; any other ce cycle restarts the run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_dma_run <= '0;
        else if (ce) begin
            if (w_sel == OWN_DMA)
                r_dma_run <= (r_dma_run == RUN_SAT) ? r_dma_run : r_dma_run + 5'd1;
            else
                r_dma_run <= '0;
        end
    end

    // Saturating count of ce cycles with more than one valid request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_conflict <= '0;
        else if (ce && (w_nreq > 2'd1) && (r_conflict != CNT_SAT))
            r_conflict <= r_conflict + 8'd1;
    end

    // Read pipeline: mark a read grant, then return RAM data at the next ce edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rdata   <= '0;
            r_wd_rv   <= 1'b0;
            r_dma_rv  <= 1'b0;
            r_cpu_rv  <= 1'b0;
        end else begin
            r_wd_rv  <= ce && r_rd_pend && (r_owner == OWN_WD);
            r_dma_rv <= ce && r_rd_pend && (r_owner == OWN_DMA);
            r_cpu_rv <= ce && r_rd_pend && (r_owner == OWN_CPU);
            if (ce) begin
                r_rd_pend <= w_granted & ~w_sel_we;
                if (r_rd_pend)
                    r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.wd_rvalid    = r_wd_rv;
    assign bus.dma_rvalid   = r_dma_rv;
    assign bus.cpu_rvalid   = r_cpu_rv;
    assign bus.rdata        = r_rdata;
    assign bus.conflict_cnt = r_conflict;

endmodule

// File: tb/tb_bufmem_arbiter.sv
// Self-checking bench for bufmem_arbiter: directed scenarios plus random
// traffic checked against a rule-level model of arbitration and the buffer.
module tb_bufmem_arbiter;

    localparam logic [15:0] BASE   = 16'h0200;
    localparam int          MAXRUN = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic ce;
    always #5 clk = ~clk;

    bufmem_arbiter_if bus();

    bufmem_arbiter #(.BUF_BASE(BASE), .DMA_MAXRUN(MAXRUN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus.slave)
    );

    // RAM1024x8 with one-cycle synchronous read
    logic [7:0] ram [1024];
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_clken) begin
            ram_q <= ram[bus.mem_addr];
            if (bus.mem_wren) ram[bus.mem_addr] = bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = ram_q;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state. Owner codes: 0 none, 1 WD, 2 DMA, 3 CPU.
    int         m_run;
    int         m_conf;
    int         m_pend;
    bit         m_pend_rd;
    logic [7:0] m_pend_data;
    int         m_rv;
    logic [7:0] m_rdata;
    logic [7:0] m_mem [1024];

    function automatic bit cpu_ok();
        return bus.cpu_req && (int'(bus.cpu_addr) >= int'(BASE)) && (int'(bus.cpu_addr) < int'(BASE) + 1024);
    endfunction

    function automatic int n_valid();
        return int'(bus.wd_req) + int'(bus.dma_req) + int'(cpu_ok());
    endfunction

    // Who gets the buffer this cycle (0 when nothing is granted)
    function automatic int exp_grant();
        if (!reset_n || !ce) return 0;
        if (bus.wd_req) return 1;
        if (cpu_ok() && m_run == MAXRUN) return 3;
        if (bus.dma_req) return 2;
        if (cpu_ok()) return 3;
        return 0;
    endfunction

    function automatic logic [2:0] owner_vec(input int o);
        return (o == 1) ? 3'b100 : (o == 2) ? 3'b010 : (o == 3) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic [9:0] exp_addr(input int g);
        int off;
        off = int'(bus.cpu_addr) - int'(BASE);
        return (g == 1) ? bus.wd_addr : (g == 2) ? bus.dma_addr : 10'(off);
    endfunction

    function automatic bit exp_we(input int g);
        return (g == 1) ? bus.wd_we : (g == 2) ? bus.dma_we : (g == 3) ? bus.cpu_we : 1'b0;
    endfunction

    function automatic logic [7:0] exp_wdata(input int g);
        return (g == 1) ? bus.wd_wdata : (g == 2) ? bus.dma_wdata : bus.cpu_wdata;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic tick();
        int g;
        g = exp_grant();
        if (reset_n && ce) begin
            m_rv = m_pend_rd ? m_pend : 0;
            if (m_pend_rd) m_rdata = m_pend_data;
            if (n_valid() > 1 && m_conf < 255) m_conf++;
            m_run     = (g == 2) ? m_run + 1 : 0;
            m_pend    = g;
            m_pend_rd = 1'b0;
            if (g != 0) begin
                if (exp_we(g)) m_mem[exp_addr(g)] = exp_wdata(g);
                else begin
                    m_pend_rd   = 1'b1;
                    m_pend_data = m_mem[exp_addr(g)];
                end
            end
        end else begin
            m_rv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_run = 0; m_conf = 0; m_pend = 0; m_pend_rd = 1'b0; m_rv = 0; m_rdata = 8'h00;
    endtask

    task automatic idle_inputs();
        bus.wd_req = 0; bus.wd_we = 0; bus.wd_addr = '0; bus.wd_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ce = 1;
        bus.wd_req = 1; bus.dma_req = 1; bus.cpu_req = 1; bus.cpu_addr = 16'h0210;
        reset_n = 0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.wd_ack, bus.dma_ack, bus.cpu_ack} !== 3'b000) begin
            n_errors++; $display("FAIL reset_acks got %b exp 000", {bus.wd_ack, bus.dma_ack, bus.cpu_ack});
        end
        n_checks++;
        if ({bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid, bus.rdata, bus.conflict_cnt} !== 19'd0) begin
            n_errors++; $display("FAIL reset_regs got rv=%b rdata=%h cnt=%h exp zeros",
                {bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid}, bus.rdata, bus.conflict_cnt);
        end
        n_checks++;
        if (bus.cpu_stall !== 1'b1 || bus.mem_clken !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall got stall=%b clken=%b exp 1 0", bus.cpu_stall, bus.mem_clken);
        end
        tick();
        n_checks++;
        if (bus.conflict_cnt !== 8'h00) begin
            n_errors++; $display("FAIL reset_hold_cnt got %h exp 00", bus.conflict_cnt);
        end
        reset_n = 1;
        idle_inputs();
        tick();
    endtask

    task automatic test_all_three();
        logic [7:0] exp_d;
        exp_d = m_mem[10'h005];
        bus.wd_req = 1; bus.wd_we = 0; bus.wd_addr = 10'h005;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 10'h100;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0210;
        ce = 1;
        #1;
        n_checks++;
        if ({bus.wd_ack, bus.dma_ack, bus.cpu_ack} !== 3'b100 || bus.mem_addr !== 10'h005) begin
            n_errors++; $display("FAIL all3_grant got acks=%b addr=%h exp 100 005",
                {bus.wd_ack, bus.dma_ack, bus.cpu_ack}, bus.mem_addr);
        end
        n_checks++;
        if (bus.cpu_stall !== 1'b1 || bus.mem_clken !== 1'b1 || bus.mem_wren !== 1'b0) begin
            n_errors++; $display("FAIL all3_ctrl got stall=%b clken=%b wren=%b exp 1 1 0",
                bus.cpu_stall, bus.mem_clken, bus.mem_wren);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (bus.conflict_cnt !== 8'd1) begin
            n_errors++; $display("FAIL all3_conflict got %0d exp 1", bus.conflict_cnt);
        end
        tick();
        n_checks++;
        if (bus.wd_rvalid !== 1'b1 || bus.rdata !== exp_d || bus.dma_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL all3_rvalid got wd_rv=%b rdata=%h exp 1 %h", bus.wd_rvalid, bus.rdata, exp_d);
        end
        tick();
        n_checks++;
        if (bus.wd_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL all3_pulse got wd_rv=%b exp 0", bus.wd_rvalid);
        end
    endtask

    task automatic test_cpu_write();
        idle_inputs();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0234; bus.cpu_wdata = 8'hA5;
        ce = 1;
        #1;
        n_checks++;
        if ({bus.wd_ack, bus.dma_ack, bus.cpu_ack} !== 3'b001 || bus.mem_addr !== 10'h034
            || bus.mem_wren !== 1'b1 || bus.mem_wdata !== 8'hA5 || bus.cpu_stall !== 1'b0) begin
            n_errors++; $display("FAIL cpu_write got acks=%b addr=%h wren=%b wdata=%h stall=%b exp 001 034 1 a5 0",
                {bus.wd_ack, bus.dma_ack, bus.cpu_ack}, bus.mem_addr, bus.mem_wren, bus.mem_wdata, bus.cpu_stall);
        end
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if ({bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid} !== 3'b000) begin
            n_errors++; $display("FAIL cpu_write_norv got %b exp 000", {bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid});
        end
    endtask

    task automatic test_dma_run();
        logic [2:0] exp_a;
        idle_inputs();
        ce = 1;
        tick();
        for (int i = 0; i < 18; i++) begin
            bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 10'(10'h200 + i); bus.dma_wdata = 8'(i);
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0300;
            #1;
            exp_a = (i == 16) ? 3'b001 : 3'b010;
            n_checks++;
            if ({bus.wd_ack, bus.dma_ack, bus.cpu_ack} !== exp_a || bus.cpu_stall !== (i != 16)) begin
                n_errors++; $display("FAIL dma_run[%0d] got acks=%b stall=%b exp %b %b",
                    i, {bus.wd_ack, bus.dma_ack, bus.cpu_ack}, bus.cpu_stall, exp_a, i != 16);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_window();
        logic [15:0] addrs [4];
        bit          hit   [4];
        logic [9:0]  offs  [4];
        addrs = '{16'h0600, 16'h01FF, 16'h05FF, 16'h0200};
        hit   = '{1'b0, 1'b0, 1'b1, 1'b1};
        offs  = '{10'h000, 10'h000, 10'h3FF, 10'h000};
        ce = 1;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = addrs[i];
            #1;
            n_checks++;
            if (bus.cpu_ack !== hit[i] || bus.cpu_stall !== 1'b0 || bus.mem_clken !== hit[i]
                || (hit[i] && bus.mem_addr !== offs[i])) begin
                n_errors++; $display("FAIL window_%h got ack=%b stall=%b clken=%b addr=%h exp %b 0 %b %h",
                    addrs[i], bus.cpu_ack, bus.cpu_stall, bus.mem_clken, bus.mem_addr, hit[i], hit[i], offs[i]);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ce_gate();
        idle_inputs();
        bus.wd_req = 1; bus.wd_we = 1; bus.wd_addr = 10'h007; bus.wd_wdata = 8'h3C;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 10'h008;
        ce = 0;
        #1;
        n_checks++;
        if ({bus.wd_ack, bus.dma_ack, bus.cpu_ack} !== 3'b000 || bus.mem_clken !== 1'b0 || bus.mem_wren !== 1'b0) begin
            n_errors++; $display("FAIL ce0_gate got acks=%b clken=%b wren=%b exp 000 0 0",
                {bus.wd_ack, bus.dma_ack, bus.cpu_ack}, bus.mem_clken, bus.mem_wren);
        end
        tick();
        n_checks++;
        if (bus.conflict_cnt !== 8'(m_conf)) begin
            n_errors++; $display("FAIL ce0_hold got %0d exp %0d", bus.conflict_cnt, m_conf);
        end
        ce = 1;
        #1;
        n_checks++;
        if (bus.wd_ack !== 1'b1 || bus.mem_clken !== 1'b1 || bus.mem_wren !== 1'b1 || bus.mem_addr !== 10'h007) begin
            n_errors++; $display("FAIL ce1_grant got ack=%b clken=%b wren=%b addr=%h exp 1 1 1 007",
                bus.wd_ack, bus.mem_clken, bus.mem_wren, bus.mem_addr);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_inflight();
        idle_inputs();
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 10'h010;
        ce = 1;
        #1;
        n_checks++;
        if (bus.dma_ack !== 1'b1) begin
            n_errors++; $display("FAIL inflight_grant got %b exp 1", bus.dma_ack);
        end
        tick();
        idle_inputs();
        #1;
        reset_n = 0;
        model_reset();
        #1;
        reset_n = 1;
        tick();
        n_checks++;
        if (bus.dma_rvalid !== 1'b0 || bus.conflict_cnt !== 8'h00) begin
            n_errors++; $display("FAIL inflight_drop got rv=%b cnt=%h exp 0 00", bus.dma_rvalid, bus.conflict_cnt);
        end
        tick();
        n_checks++;
        if ({bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid} !== 3'b000) begin
            n_errors++; $display("FAIL inflight_late got %b exp 000", {bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid});
        end
    endtask

    task automatic test_random();
        int g;
        for (int n = 0; n < 400; n++) begin
            ce            = ($urandom_range(0, 3) != 0);
            bus.wd_req    = ($urandom_range(0, 5) == 0);
            bus.wd_we     = $urandom_range(0, 1) != 0;
            bus.wd_addr   = 10'($urandom);
            bus.wd_wdata  = 8'($urandom);
            bus.dma_req   = ($urandom_range(0, 9) < 7);
            bus.dma_we    = $urandom_range(0, 1) != 0;
            bus.dma_addr  = 10'($urandom);
            bus.dma_wdata = 8'($urandom);
            bus.cpu_req   = $urandom_range(0, 1) != 0;
            bus.cpu_we    = $urandom_range(0, 1) != 0;
            bus.cpu_addr  = 16'(32'h0100 + $urandom_range(0, 16'h05FF));
            bus.cpu_wdata = 8'($urandom);
            #1;
            g = exp_grant();
            n_checks++;
            if ({bus.wd_ack, bus.dma_ack, bus.cpu_ack} !== owner_vec(g) || bus.mem_clken !== (g != 0)
                || bus.mem_wren !== (g != 0 && exp_we(g)) || bus.cpu_stall !== (cpu_ok() && g != 3)) begin
                n_errors++; $display("FAIL rnd_ctrl[%0d] got acks=%b clken=%b wren=%b stall=%b exp %b %b %b %b",
                    n, {bus.wd_ack, bus.dma_ack, bus.cpu_ack}, bus.mem_clken, bus.mem_wren, bus.cpu_stall,
                    owner_vec(g), g != 0, g != 0 && exp_we(g), cpu_ok() && g != 3);
            end
            if (g != 0) begin
                n_checks++;
                if (bus.mem_addr !== exp_addr(g) || bus.mem_wdata !== exp_wdata(g)) begin
                    n_errors++; $display("FAIL rnd_bus[%0d] got addr=%h wdata=%h exp %h %h",
                        n, bus.mem_addr, bus.mem_wdata, exp_addr(g), exp_wdata(g));
                end
            end
            tick();
            n_checks++;
            if ({bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid} !== owner_vec(m_rv) || bus.rdata !== m_rdata
                || bus.conflict_cnt !== 8'(m_conf)) begin
                n_errors++; $display("FAIL rnd_ret[%0d] got rv=%b rdata=%h cnt=%0d exp %b %h %0d",
                    n, {bus.wd_rvalid, bus.dma_rvalid, bus.cpu_rvalid}, bus.rdata, bus.conflict_cnt,
                    owner_vec(m_rv), m_rdata, m_conf);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = 8'($urandom);
            ram[i]   = v;
            m_mem[i] = v;
        end
        idle_inputs();
        ce      = 0;
        reset_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_all_three();
        test_cpu_write();
        test_dma_run();
        test_window();
        test_ce_gate();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bufmem_arbiter.md
BUFMEM_ARBITER -- requirements
Module: bufmem_arbiter

Interface
REQ-001 SHALL have parameter BUF_BASE, default 16'h0200: CPU-side base address of the 1 KiB sector buffer.
REQ-002 SHALL have parameter DMA_MAXRUN, default 16: maximum consecutive DMA grants while CPU is waiting.
REQ-003 SHALL have port clk  in  1: single clock; all state on posedge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port ce  in  1: clock enable; arbitration occurs only in ce cycles.
REQ-006 SHALL have ports wd_req/wd_we  in  1, wd_addr  in  10, wd_wdata  in  8: WD1793 buffer port.
REQ-007 SHALL have ports dma_req/dma_we  in  1, dma_addr  in  10, dma_wdata  in  8: DMA engine port.
REQ-008 SHALL have ports cpu_req/cpu_we  in  1, cpu_addr  in  16, cpu_wdata  in  8: 6502 port.
REQ-009 SHALL have outputs wd_ack, dma_ack, cpu_ack  out  1: access granted this ce cycle.
REQ-010 SHALL have outputs wd_rvalid, dma_rvalid, cpu_rvalid  out  1, rdata  out  8: read return.
REQ-011 SHALL have output cpu_stall  out  1: gate for the CPU enable.
REQ-012 SHALL have outputs mem_addr  out  10, mem_wdata  out  8, mem_wren  out  1, mem_clken  out  1, and input mem_rdata  in  8: RAM1024x8 port, 1-cycle synchronous read.
REQ-013 SHALL have output conflict_cnt  out  8: saturating contention counter.

Function
REQ-014 CPU request SHALL be valid only when cpu_req=1 and BUF_BASE <= cpu_addr < BUF_BASE+1024; out of window: no ack, no stall.
REQ-015 Priority in each ce cycle: WD > DMA > CPU, except per REQ-017.
REQ-016 Grant SHALL be combinational from same-cycle requests: the winner's ack=1; mem_addr, mem_wdata, and mem_wren=we come from the winner; mem_clken=ce & any grant.
REQ-017 dma_run (5-bit) SHALL count consecutive DMA grants and clear on any non-DMA grant or idle cycle; when dma_run==DMA_MAXRUN and the CPU request is valid and wd_req=0, the CPU SHALL win once.
REQ-018 CPU mem_addr SHALL be (cpu_addr-BUF_BASE)[9:0].
REQ-019 cpu_stall SHALL equal (valid CPU request) & ~cpu_ack, combinationally, including ce=0 cycles.
REQ-020 On a read grant, the owner's rvalid SHALL pulse for exactly one clock at the next ce cycle, with rdata=mem_rdata; write grants produce no rvalid.
REQ-021 When ce=0: all acks=0, mem_wren=0, mem_clken=0, and all state is held.
REQ-022 conflict_cnt SHALL increment in each ce cycle where more than one request is valid, saturating at 8'hFF.
REQ-023 The owner register (NONE/WD/DMA/CPU) SHALL record the last grant; it drives rdata routing and is NONE after an idle ce cycle.
REQ-024 Simultaneous rvalid return and a new grant SHALL both be honoured (pipelined; full throughput of one access per ce cycle).

Reset
REQ-025 With reset_n=0, asynchronously: owner=NONE, dma_run=0, conflict_cnt=0, all rvalid=0, rdata=0.
REQ-026 A read in flight when reset asserts SHALL be dropped; no rvalid after release.
REQ-027 Combinational outputs SHALL follow their inputs during reset; acks SHALL be forced 0 while reset_n=0.

Verification
REQ-028 All three request, ce=1, wd_we=0, wd_addr=0x005 -> wd_ack=1, mem_addr=0x005, cpu_stall=1, conflict_cnt+1; next ce: wd_rvalid=1.
REQ-029 CPU write at cpu_addr=0x0234, data 0xA5, alone -> cpu_ack=1, mem_addr=0x034, mem_wren=1, mem_wdata=0xA5, no rvalid.
REQ-030 DMA continuous plus CPU pending for 17 ce cycles -> 16 DMA acks, then CPU ack at the 17th, then DMA resumes.
REQ-031 cpu_addr=0x0600 with cpu_req=1 -> no ack, cpu_stall=0, mem_clken=0.
REQ-032 Reset pulse the cycle after a DMA read grant -> dma_rvalid stays 0; conflict_cnt=0.
REQ-033 ce=0 with WD requesting -> no ack, mem_clken=0; ce=1 next cycle -> wd_ack=1.
